// File: rtl/piece_scheduler_pkg.sv
// Shared definitions for the piece scheduler: piece ids, colour table, FSM states.
// Optional feature macro used by piece_scheduler: PIECE_REROLL_EN.
package piece_scheduler_pkg;

  localparam int unsigned PIECE_W    = 3;
  localparam int unsigned COLOUR_W   = 3;
  localparam int unsigned COUNT_W    = 8;
  localparam int unsigned NUM_PIECES = 7;

  localparam logic [PIECE_W-1:0] PIECE_I = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_O = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_T = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_S = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_Z = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_J = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_L = 3'd6;

  // Entry n is the colour of piece id n (cyan, yellow, purple, green, red, blue, orange).
  localparam logic [NUM_PIECES-1:0][COLOUR_W-1:0] COLOUR_TABLE =
    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  // Colour lookup; out-of-range ids map to colour 0.
  function automatic logic [COLOUR_W-1:0] piece_colour_f(input logic [PIECE_W-1:0] id);
    logic [COLOUR_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_PIECES; i++) begin
      if (id == PIECE_W'(i)) c = COLOUR_TABLE[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/piece_slot_queue.sv
// Two-entry head/preview shift register with valid bits and registered head colour.
// Ports: clk, reset (sync, active-high); clear_i empties both slots; pop_i shifts
// preview into head; push_i writes push_id_i into the first empty slot after any pop.
// Outputs: head_valid_o/head_id_o/head_colour_o, preview_valid_o/preview_id_o
// (ids and colour read 0 while the slot is empty).
module piece_slot_queue
  import piece_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                pop_i,
  input  logic                push_i,
  input  logic [PIECE_W-1:0]  push_id_i,
  output logic                head_valid_o,
  output logic [PIECE_W-1:0]  head_id_o,
  output logic [COLOUR_W-1:0] head_colour_o,
  output logic                preview_valid_o,
  output logic [PIECE_W-1:0]  preview_id_o
);

  logic                head_valid_q, head_valid_d;
  logic [PIECE_W-1:0]  head_id_q, head_id_d;
  logic [COLOUR_W-1:0] head_colour_q, head_colour_d;
  logic                prev_valid_q, prev_valid_d;
  logic [PIECE_W-1:0]  prev_id_q, prev_id_d;

  // Pop happens before push, so a push on a pop edge with empty preview lands in head.
  always_comb begin
    head_valid_d = head_valid_q;
    head_id_d    = head_id_q;
    prev_valid_d = prev_valid_q;
    prev_id_d    = prev_id_q;
    if (clear_i) begin
      head_valid_d = 1'b0;
      head_id_d    = '0;
      prev_valid_d = 1'b0;
      prev_id_d    = '0;
    end else begin
      if (pop_i) begin
        head_valid_d = prev_valid_q;
        head_id_d    = prev_id_q;
        prev_valid_d = 1'b0;
        prev_id_d    = '0;
      end
      if (push_i) begin
        if (!head_valid_d) begin
          head_valid_d = 1'b1;
          head_id_d    = push_id_i;
        end else begin
          prev_valid_d = 1'b1;
          prev_id_d    = push_id_i;
        end
      end
    end
    head_colour_d = head_valid_d ? piece_colour_f(head_id_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid_q  <= 1'b0;
      head_id_q     <= '0;
      head_colour_q <= '0;
      prev_valid_q  <= 1'b0;
      prev_id_q     <= '0;
    end else begin
      head_valid_q  <= head_valid_d;
      head_id_q     <= head_id_d;
      head_colour_q <= head_colour_d;
      prev_valid_q  <= prev_valid_d;
      prev_id_q     <= prev_id_d;
    end
  end

  assign head_valid_o    = head_valid_q;
  assign head_id_o       = head_id_q;
  assign head_colour_o   = head_colour_q;
  assign preview_valid_o = prev_valid_q;
  assign preview_id_o    = prev_id_q;

endmodule

// File: rtl/piece_scheduler.sv
// Piece scheduler: samples a free-running random value into a head/preview queue,
// hands the head piece to a consumer and counts deliveries.
// Ports: clk, reset (sync, active-high), rnd_in[2:0] (0 invalid, n -> piece n-1),
// start (restart stream), piece_req (take head); outputs piece_valid, piece_id,
// piece_colour, preview_valid, preview_id, draw_count[7:0] (all registered).
// Optional feature: define PIECE_REROLL_EN to discard, once, a sample repeating
// the last accepted piece.
module piece_scheduler
  import piece_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [PIECE_W-1:0]  rnd_in,
  input  logic                start,
  input  logic                piece_req,
  output logic                piece_valid,
  output logic [PIECE_W-1:0]  piece_id,
  output logic [COLOUR_W-1:0] piece_colour,
  output logic                preview_valid,
  output logic [PIECE_W-1:0]  preview_id,
  output logic [COUNT_W-1:0]  draw_count
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 q_clear, q_pop, q_push;
  logic                 accept;
  logic                 take;
  logic [PIECE_W-1:0]   cand_id;

  assign accept  = piece_req & piece_valid;
  assign cand_id = PIECE_W'(rnd_in - 3'd1);

`ifdef PIECE_REROLL_EN
  logic [PIECE_W-1:0] last_q, last_d;
  logic               last_valid_q, last_valid_d;
  logic               reroll_q, reroll_d;
`endif

  // Sample filter: decides whether this edge's rnd_in enters the queue.
  always_comb begin
    take = 1'b0;
`ifdef PIECE_REROLL_EN
    last_d       = last_q;
    last_valid_d = last_valid_q;
    reroll_d     = reroll_q;
`endif
    if (state_q == FILL && !start && rnd_in != '0) begin
`ifdef PIECE_REROLL_EN
      // A repeat is discarded only once; the following nonzero sample always lands.
      if (!reroll_q && last_valid_q && cand_id == last_q) begin
        reroll_d = 1'b1;
      end else begin
        take         = 1'b1;
        reroll_d     = 1'b0;
        last_d       = cand_id;
        last_valid_d = 1'b1;
      end
`else
      take = 1'b1;
`endif
    end
`ifdef PIECE_REROLL_EN
    if (start) begin
      last_d       = '0;
      last_valid_d = 1'b0;
      reroll_d     = 1'b0;
    end
`endif
  end

  // FSM next-state and queue control.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_clear = 1'b0;
    q_pop   = 1'b0;
    q_push  = 1'b0;
    if (start) begin
      state_d = FILL;
      count_d = '0;
      q_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        FILL: begin
          q_pop  = accept;
          q_push = take;
          if (accept) count_d = count_q + COUNT_W'(1);
          // Preview is always empty in FILL; a sample fills it only if head survives.
          if (take && piece_valid && !accept) state_d = FULL;
        end
        FULL: begin
          if (accept) begin
            q_pop   = 1'b1;
            count_d = count_q + COUNT_W'(1);
            state_d = FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
`ifdef PIECE_REROLL_EN
      last_q       <= '0;
      last_valid_q <= 1'b0;
      reroll_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef PIECE_REROLL_EN
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      reroll_q     <= reroll_d;
`endif
    end
  end

  piece_slot_queue u_queue (
    .clk             (clk),
    .reset           (reset),
    .clear_i         (q_clear),
    .pop_i           (q_pop),
    .push_i          (q_push),
    .push_id_i       (cand_id),
    .head_valid_o    (piece_valid),
    .head_id_o       (piece_id),
    .head_colour_o   (piece_colour),
    .preview_valid_o (preview_valid),
    .preview_id_o    (preview_id)
  );

  assign draw_count = count_q;

endmodule

// File: tb/tb_piece_scheduler.sv
// Testbench for piece_scheduler: directed steps plus randomized traffic against a
// queue-based reference model.
module tb_piece_scheduler;
  import piece_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, piece_req;
  logic [2:0] rnd_in;
  logic       piece_valid, preview_valid;
  logic [2:0] piece_id, piece_colour, preview_id;
  logic [7:0] draw_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_idle = 1'b1;
  int m_q[$];
  int m_count = 0;
`ifdef PIECE_REROLL_EN
  bit m_last_v = 1'b0;
  int m_last = 0;
  bit m_reroll = 1'b0;
`endif
  int colour_tab[7] = '{1, 2, 3, 4, 5, 6, 7};

  piece_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .rnd_in        (rnd_in),
    .start         (start),
    .piece_req     (piece_req),
    .piece_valid   (piece_valid),
    .piece_id      (piece_id),
    .piece_colour  (piece_colour),
    .preview_valid (preview_valid),
    .preview_id    (preview_id),
    .draw_count    (draw_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit idle);
    m_idle = idle;
    m_q.delete();
    m_count = 0;
`ifdef PIECE_REROLL_EN
    m_last_v = 1'b0;
    m_last = 0;
    m_reroll = 1'b0;
`endif
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_edge(input bit rst, input bit st, input bit req, input int rnd);
    bit was_full;
    bit keep;
    int c;
    if (rst) model_clear(1'b1);
    else if (st) model_clear(1'b0);
    else if (!m_idle) begin
      was_full = (m_q.size() == 2);
      if (req && m_q.size() > 0) begin
        void'(m_q.pop_front());
        m_count = (m_count + 1) % 256;
      end
      if (!was_full && rnd != 0) begin
        c = rnd - 1;
        keep = 1'b1;
`ifdef PIECE_REROLL_EN
        if (!m_reroll && m_last_v && c == m_last) begin
          keep = 1'b0;
          m_reroll = 1'b1;
        end else begin
          m_reroll = 1'b0;
          m_last = c;
          m_last_v = 1'b1;
        end
`endif
        if (keep) m_q.push_back(c);
      end
    end
  endtask

  task automatic check_all(input string tag);
    int hid, pid, col;
    state_e st;
    hid = (m_q.size() > 0) ? m_q[0] : 0;
    pid = (m_q.size() > 1) ? m_q[1] : 0;
    col = (m_q.size() > 0) ? colour_tab[m_q[0]] : 0;
    st  = m_idle ? IDLE : ((m_q.size() == 2) ? FULL : FILL);
    check({tag, ".piece_valid"},   32'(piece_valid),   32'(m_q.size() > 0));
    check({tag, ".piece_id"},      32'(piece_id),      32'(hid));
    check({tag, ".piece_colour"},  32'(piece_colour),  32'(col));
    check({tag, ".preview_valid"}, 32'(preview_valid), 32'(m_q.size() > 1));
    check({tag, ".preview_id"},    32'(preview_id),    32'(pid));
    check({tag, ".draw_count"},    32'(draw_count),    32'(m_count));
    check({tag, ".state"},         32'(dut.state_q),   32'(st));
  endtask

  task automatic step(input string tag, input bit rst, input bit st, input bit req,
                      input logic [2:0] rnd);
    reset = rst; start = st; piece_req = req; rnd_in = rnd;
    model_edge(rst, st, req, int'(rnd));
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] r, prev;
    reset = 1'b1; start = 1'b0; piece_req = 1'b0; rnd_in = 3'd0;

    // Reset state
    step("rst0", 1, 0, 0, 3'd0);
    step("rst1", 1, 1, 1, 3'd5);

    // Idle ignores samples and requests
    step("idle", 0, 0, 1, 3'd4);

    // Start then samples 3, 5 -> head T(2), preview Z(4), FULL
    step("start", 0, 1, 0, 3'd3);
    step("s3", 0, 0, 0, 3'd3);
    check("s3.id_const", 32'(piece_id), 32'd2);
    step("s5", 0, 0, 0, 3'd5);
    check("s5.prev_const", 32'(preview_id), 32'd4);
    check("s5.full_const", 32'(dut.state_q), 32'(FULL));

    // FULL holds without sampling
    step("hold0", 0, 0, 0, 3'd1);
    step("hold1", 0, 0, 0, 3'd6);

    // Accept from FULL, then refill with 7
    step("acc", 0, 0, 1, 3'd2);
    check("acc.id_const", 32'(piece_id), 32'd4);
    check("acc.cnt_const", 32'(draw_count), 32'd1);
    step("refill", 0, 0, 0, 3'd7);
    check("refill.prev_const", 32'(preview_id), 32'd6);

    // Restart wins over a simultaneous request
    step("restart", 0, 1, 1, 3'd4);

    // rnd_in held at 0 for 10 cycles
    for (int i = 0; i < 10; i++) step("zero", 0, 0, 1, 3'd0);

    // Repeat-sample handling: head O(1), then samples 2,2,2
    step("rr_start", 0, 1, 0, 3'd0);
    step("rr_head", 0, 0, 0, 3'd2);
    step("rr_a", 0, 0, 0, 3'd2);
`ifdef PIECE_REROLL_EN
    check("rr_a.prev_valid_const", 32'(preview_valid), 32'd0);
`else
    check("rr_a.prev_id_const", 32'(preview_id), 32'd1);
`endif
    step("rr_b", 0, 0, 0, 3'd2);
    check("rr_b.prev_id_const", 32'(preview_id), 32'd1);
    step("rr_c", 0, 0, 0, 3'd2);

    // Reset mid-FILL with a request pending
    step("mf_start", 0, 1, 0, 3'd0);
    step("mf_s", 0, 0, 0, 3'd3);
    step("mf_rst", 1, 0, 1, 3'd4);
    check("mf_rst.valid_const", 32'(piece_valid), 32'd0);

    // 256 accepts with non-repeating nonzero samples; counter wraps, head never empties
    step("wrap_start", 0, 1, 0, 3'd0);
    prev = 3'd0;
    for (int i = 0; i < 257; i++) begin
      do r = 3'($urandom_range(1, 7)); while (r == prev);
      prev = r;
      step("wrap", 0, 0, 1, r);
      check("wrap.valid_const", 32'(piece_valid), 32'd1);
    end
    check("wrap.cnt_const", 32'(draw_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
